fetch_stage: RTL and testbench

Instruction fetch stage of the five-stage pipeline, upstream of the decode/execute register. Holds the PC and issues in-order sequential requests to a variable-latency instruction memory through a request/grant handshake. Returned words go into a small prefetch FIFO, then into the IF/ID output register that feeds decode. Branch/jump redirects from execute flush the FIFO and discard in-flight responses.

---
 rtl/fetch_stage.sv | 142 ++++++++++++++
 tb/tb_fetch_stage.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, request/grant memory port, prefetch FIFO
// and the IF/ID register feeding decode.
module fetch_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [31:0]           imem_rdata,
    input  logic                  PCSrcE,
    input  logic [DATA_WIDTH-1:0] PCTargetE,
    input  logic                  StallD,
    output logic [31:0]           InstrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PC_PlusD,
    output logic                  ValidD
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = $clog2(2 * FIFO_DEPTH) + 1;
    localparam int CW = OW + 1;
    localparam logic [AW:0]           DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0]         LIMIT_C = CW'(FIFO_DEPTH);
    localparam logic [31:0]           NOP     = 32'h0000_0013;
    localparam logic [DATA_WIDTH-1:0] STEP    = DATA_WIDTH'(4);

    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] rpc;
    logic [31:0]           fifo_instr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_pc    [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           occ;
    logic [OW-1:0]         outst;
    logic [OW-1:0]         kill;

    logic                  empty;
    logic                  full;
    logic                  pop;
    logic                  rsp;
    logic                  discard;
    logic                  push;
    logic                  xfer;
    logic [CW-1:0]         live;
    logic [AW:0]           occ_n;
    logic [OW-1:0]         outst_n;
    logic [OW-1:0]         kill_n;

    // Slots that will be occupied once everything still wanted has landed.
    always_comb begin
        empty   = (occ == '0);
        full    = (occ == DEPTH_C);
        pop     = !empty && !StallD && !PCSrcE;
        rsp     = imem_rvalid && (outst != '0);
        discard = (kill != '0) || PCSrcE;
        push    = rsp && !discard;
        live    = CW'(occ) - CW'(pop) + CW'(outst) - CW'(kill);
        imem_req  = !rst && !PCSrcE && (live < LIMIT_C);
        imem_addr = pc;
        xfer    = imem_req && imem_gnt;
    end

    always_comb begin
        outst_n = outst + OW'(xfer) - OW'(rsp);
        occ_n   = occ + (AW + 1)'(push) - (AW + 1)'(pop);
        kill_n  = kill;
        if (PCSrcE) begin
            occ_n  = '0;
            kill_n = outst - OW'(rsp);
        end else if (rsp && (kill != '0)) begin
            kill_n = kill - OW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_PC;
            rpc    <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            outst  <= '0;
            kill   <= '0;
        end else begin
            occ   <= occ_n;
            outst <= outst_n;
            kill  <= kill_n;
            if (PCSrcE) begin
                pc     <= PCTargetE;
                rpc    <= PCTargetE;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (xfer) pc <= pc + STEP;
                if (push) begin
                    rpc    <= rpc + STEP;
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_pc[wr_ptr]    <= rpc;
        end
    end

    // Redirect beats a decode stall: the held instruction is on a dead path.
    always_ff @(posedge clk) begin
        if (rst || PCSrcE) begin
            InstrD   <= NOP;
            PCD      <= '0;
            PC_PlusD <= '0;
            ValidD   <= 1'b0;
        end else if (!StallD) begin
            if (pop) begin
                InstrD   <= fifo_instr[rd_ptr];
                PCD      <= fifo_pc[rd_ptr];
                PC_PlusD <= fifo_pc[rd_ptr] + STEP;
                ValidD   <= 1'b1;
            end else begin
                InstrD   <= NOP;
                PCD      <= '0;
                PC_PlusD <= '0;
                ValidD   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) assert (!(push && full && !pop));
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: latency-programmable memory model, stream-level
// reference of delivered PCs, and directed literal checks.
module tb_fetch_stage;

    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          imem_req;
    logic [DW-1:0] imem_addr;
    logic          imem_gnt = 1'b1;
    logic          imem_rvalid = 1'b0;
    logic [31:0]   imem_rdata = 32'h0;
    logic          PCSrcE = 1'b0;
    logic [DW-1:0] PCTargetE = '0;
    logic          StallD = 1'b0;
    logic [31:0]   InstrD;
    logic [DW-1:0] PCD;
    logic [DW-1:0] PC_PlusD;
    logic          ValidD;

    fetch_stage #(
        .DATA_WIDTH(DW),
        .RESET_PC  (32'h0),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .StallD     (StallD),
        .InstrD     (InstrD),
        .PCD        (PCD),
        .PC_PlusD   (PC_PlusD),
        .ValidD     (ValidD)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat     = 1;
    bit chk_inflight = 1'b0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    req_t mq[$];

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a | 32'h13;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: answers in order, each no earlier than its due cycle.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memf(mq[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'hdead_beef;
        end
    end

    logic [31:0] fpc, exp_pc;
    bit          started = 1'b0;
    bit          prev_rst, prev_red, prev_stall;
    logic        pv;
    logic [31:0] pi, ppc, ppp;

    // Stream reference: decode sees PCs in +4 order from the last
    // reset/redirect target, each with its own memory word.
    always @(negedge clk) begin
        if (rst) begin
            if (started) check("req_in_reset", imem_req, 0);
            started    = 1'b1;
            mq.delete();
            fpc        = 32'h0;
            exp_pc     = 32'h0;
            prev_rst   = 1'b1;
            prev_red   = 1'b0;
            prev_stall = 1'b0;
        end else if (started) begin
            if (PCSrcE) check("req_on_redirect", imem_req, 0);
            else if (imem_req) check("fetch_addr", imem_addr, fpc);
            if (prev_rst || prev_red) begin
                check("flush_valid", ValidD, 0);
                check("flush_instr", InstrD, 32'h13);
                check("flush_pcd", PCD, 0);
                check("flush_pcplus", PC_PlusD, 0);
            end else if (prev_stall) begin
                check("hold_valid", ValidD, pv);
                check("hold_instr", InstrD, pi);
                check("hold_pcd", PCD, ppc);
                check("hold_pcplus", PC_PlusD, ppp);
            end else if (ValidD) begin
                check("stream_pcd", PCD, exp_pc);
                check("stream_instr", InstrD, memf(exp_pc));
                check("stream_pcplus", PC_PlusD, exp_pc + 4);
                exp_pc = exp_pc + 4;
            end else begin
                check("bubble_instr", InstrD, 32'h13);
                check("bubble_pcd", PCD, 0);
                check("bubble_pcplus", PC_PlusD, 0);
            end
            if (chk_inflight) check("inflight_limit", mq.size() <= DEPTH, 1);
            if (imem_rvalid && mq.size() > 0) void'(mq.pop_front());
            if (imem_req && imem_gnt) mq.push_back('{imem_addr, cyc + lat});
            if (PCSrcE) begin
                fpc    = PCTargetE;
                exp_pc = PCTargetE;
            end else if (imem_req && imem_gnt) begin
                fpc = fpc + 4;
            end
            prev_rst   = 1'b0;
            prev_red   = PCSrcE;
            prev_stall = StallD;
        end
        pv  = ValidD;
        pi  = InstrD;
        ppc = PCD;
        ppp = PC_PlusD;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int          nb, nv;
    bit          found;
    logic [31:0] a0;

    initial begin
        tick();
        tick();
        rst = 1'b0;
        sample();
        check("rst_valid", ValidD, 0);
        check("rst_instr", InstrD, 32'h13);
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, 0);
        tick(); sample();
        check("second_addr", imem_addr, 4);
        check("c1_valid", ValidD, 0);
        tick(); sample();
        check("c2_valid", ValidD, 0);
        tick(); sample();
        check("c3_valid", ValidD, 1);
        check("c3_pcd", PCD, 0);
        check("c3_instr", InstrD, 32'h13);
        check("c3_pcplus", PC_PlusD, 4);
        tick(); sample();
        check("c4_pcd", PCD, 4);
        check("c4_instr", InstrD, 32'h17);
        tick(); sample();
        check("c5_pcd", PCD, 8);
        check("c5_instr", InstrD, 32'h1b);
        tick(); sample();
        check("c6_valid", ValidD, 1);
        check("c6_pcd", PCD, 32'hc);
        check("c6_instr", InstrD, 32'h1f);

        tick(); StallD = 1'b1; sample();
        check("stall1_req", imem_req, 0);
        tick(); sample();
        check("stall2_req", imem_req, 0);
        tick(); sample();
        check("stall3_req", imem_req, 0);
        tick(); StallD = 1'b0; sample();
        check("unstall_req", imem_req, 1);
        run(5);

        lat = 3;
        chk_inflight = 1'b1;
        nb = 0;
        nv = 0;
        for (int i = 0; i < 24; i++) begin
            tick(); sample();
            if (ValidD) nv++;
            else nb++;
        end
        check("lat3_bubbles", nb > 0, 1);
        check("lat3_progress", nv > 0, 1);

        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (imem_rvalid && mq.size() == 2) found = 1'b1;
        end
        check("redir_setup", found, 1);
        chk_inflight = 1'b0;
        PCSrcE    = 1'b1;
        PCTargetE = 32'h100;
        sample();
        check("redir_req", imem_req, 0);
        tick(); PCSrcE = 1'b0; sample();
        check("redir_bubble", ValidD, 0);
        check("redir_nop", InstrD, 32'h13);
        check("redir_req_next", imem_req, 1);
        check("redir_addr_next", imem_addr, 32'h100);
        for (int i = 0; i < 30 && !ValidD; i++) begin
            tick(); sample();
        end
        check("redir_valid", ValidD, 1);
        check("redir_pcd", PCD, 32'h100);
        check("redir_instr", InstrD, 32'h113);

        lat = 1;
        run(6);
        tick(); StallD = 1'b1;
        tick();
        tick(); PCSrcE = 1'b1; PCTargetE = 32'h200; sample();
        check("sr_req", imem_req, 0);
        tick(); PCSrcE = 1'b0; StallD = 1'b0; sample();
        check("sr_bubble", ValidD, 0);
        for (int i = 0; i < 30 && !ValidD; i++) begin
            tick(); sample();
        end
        check("sr_valid", ValidD, 1);
        check("sr_pcd", PCD, 32'h200);
        check("sr_instr", InstrD, 32'h213);

        run(3);
        tick(); imem_gnt = 1'b0; sample();
        a0 = imem_addr;
        check("gnt_req", imem_req, 1);
        for (int i = 0; i < 3; i++) begin
            tick(); sample();
            check("gnt_hold_addr", imem_addr, a0);
            check("gnt_hold_req", imem_req, 1);
        end
        tick(); imem_gnt = 1'b1; sample();
        check("gnt_addr", imem_addr, a0);
        tick(); sample();
        check("gnt_advance", imem_addr, a0 + 4);

        run(3);
        tick(); rst = 1'b1; sample();
        check("mid_rst_req", imem_req, 0);
        tick(); rst = 1'b0; sample();
        check("mid_rst_valid", ValidD, 0);
        check("mid_rst_instr", InstrD, 32'h13);
        check("mid_rst_pcd", PCD, 0);
        check("mid_rst_pcplus", PC_PlusD, 0);
        check("mid_rst_addr", imem_addr, 0);
        run(3); sample();
        check("post_rst_valid", ValidD, 1);
        check("post_rst_pcd", PCD, 0);
        run(5);
        sample();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
